multi_channel_debouncer: RTL

Parametrised successor to the three-channel switch debouncer. It debounces CHANNELS asynchronous switch or button inputs in the single system clock domain, using a clock-enable tick instead of a divided clock. A change is accepted only after it has been seen on STABLE_TICKS consecutive ticks. Each channel also produces one-cycle rising and falling edge pulses. The block sits between board switches/buttons and the control FSMs (START/CLEAR/RESET and similar).

---
 rtl/multi_channel_debouncer.sv | 117 +++++++++++
 1 files changed

// File: rtl/multi_channel_debouncer.sv
// rtl/multi_channel_debouncer.sv - tick-sampled multi-channel switch debouncer with edge pulses
// Two-flop synchroniser, shared prescaler tick, and a per-channel STABLE/PENDING qualifier.
module multi_channel_debouncer #(
   parameter int                  CHANNELS     = 3,
   parameter int                  CLK_DIV      = 100000,
   parameter int                  STABLE_TICKS = 4,
   parameter logic [CHANNELS-1:0] RST_VALUE    = '0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] I,
   output logic [CHANNELS-1:0] D,
   output logic [CHANNELS-1:0] RISE,
   output logic [CHANNELS-1:0] FALL,
   output logic                TICK
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS) + 1;
   localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
   localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

   typedef enum logic {ST_STABLE, ST_PENDING} state_t;

   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s;
   logic [PW-1:0]       p;
   state_t              state_q [CHANNELS];
   state_t              state_d [CHANNELS];
   logic [CW-1:0]       cnt_q   [CHANNELS];
   logic [CW-1:0]       cnt_d   [CHANNELS];
   logic [CHANNELS-1:0] accept;
   logic [CHANNELS-1:0] d_next;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= RST_VALUE;
         s  <= RST_VALUE;
         p  <= '0;
      end else begin
         s1 <= I;
         s  <= s1;
         p  <= (p == P_LAST) ? '0 : p + 1'b1;
      end
   end

   assign TICK = (p == P_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         D    <= RST_VALUE;
         RISE <= '0;
         FALL <= '0;
         for (int n = 0; n < CHANNELS; n++) begin
            state_q[n] <= ST_STABLE;
            cnt_q[n]   <= '0;
         end
      end else begin
         D    <= d_next;
         RISE <= rise_d;
         FALL <= fall_d;
         for (int n = 0; n < CHANNELS; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
         end
      end
   end

   // Outside tick cycles everything holds except the edge pulses, which drop to 0.
   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         state_d[n] = state_q[n];
         cnt_d[n]   = cnt_q[n];
         accept[n]  = 1'b0;
         d_next[n]  = D[n];
         rise_d[n]  = 1'b0;
         fall_d[n]  = 1'b0;
         if (TICK) begin
            case (state_q[n])
               ST_STABLE: begin
                  if (s[n] != D[n]) begin
                     if (STABLE_TICKS == 1) begin
                        accept[n] = 1'b1;
                        cnt_d[n]  = '0;
                     end else begin
                        state_d[n] = ST_PENDING;
                        cnt_d[n]   = CW'(1);
                     end
                  end else begin
                     cnt_d[n] = '0;
                  end
               end
               ST_PENDING: begin
                  if (s[n] == D[n]) begin
                     state_d[n] = ST_STABLE;
                     cnt_d[n]   = '0;
                  end else if (cnt_q[n] == C_LAST) begin
                     accept[n]  = 1'b1;
                     state_d[n] = ST_STABLE;
                     cnt_d[n]   = '0;
                  end else begin
                     cnt_d[n] = cnt_q[n] + 1'b1;
                  end
               end
            endcase
         end
         if (accept[n]) begin
            d_next[n] = s[n];
            rise_d[n] = s[n];
            fall_d[n] = ~s[n];
         end
      end
   end

endmodule
